// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// opcodes, the FSM state encoding, ALU operation classes, mux selects
// and the packed control-strobe bundle driven by ctrl_out_decode.
package mips_ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  // Supported opcodes
  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

  // Operation classes consumed by ALU_Ctrl
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_SLTI  = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // Datapath control strobes for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // True for the opcodes this core implements
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_R)    || (op == OP_J)    || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_LW)  ||
           (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational strobe decoder: current state plus opcode (live in DECODE,
// latched afterwards) and memory ready -> control strobe bundle.
// The TRAP state decodes only when MULTICYCLE_ILLEGAL_TRAP_EN is defined;
// otherwise encoding 12 is treated like the other unused encodings.
import mips_ctrl_pkg::*;

module ctrl_out_decode (
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_mem_ready,
  output ctrl_t           o_ctrl
);

  // Per-state strobes; anything not set for a state stays 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        // IR and PC load only in the cycle the fetch completes
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.illegal   = !op_supported(i_op);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_REXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RT;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PCSRC_JUMP;
      end
      S_IEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = (i_op == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
      end
      S_IWB: begin
        o_ctrl.reg_write = 1'b1;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        o_ctrl.illegal = 1'b1;
      end
`endif
      default: begin
        // Unused encoding: flag it for the single cycle before recovery
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU. Holds the state
// register, the opcode latch and next-state logic; strobes come from
// ctrl_out_decode. Optional macro MULTICYCLE_ILLEGAL_TRAP_EN sends an
// unsupported opcode to a halting TRAP state instead of treating it as a NOP.
// Memory handshake: a request (mem_read_o/mem_write_o) is held until the
// cycle mem_ready_i=1, which completes it; mem_ready_i is ignored elsewhere.
import mips_ctrl_pkg::*;

module multicycle_ctrl (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] instr_op_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic [1:0]      pc_src_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            ir_write_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [2:0]      alu_op_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic [OP_W-1:0] w_op;
  ctrl_t           w_ctrl;
  ctrl_t           w_ctrl_out;

  // Opcode is only valid on the bus during DECODE; later states use the latch
  assign w_op = (r_state == S_DECODE) ? instr_op_i : r_op;

  // State register and opcode latch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= instr_op_i;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_REXEC;
          OP_BEQ:           w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_ADDI, OP_SLTI: w_next = S_IEXEC;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:          w_next = S_TRAP;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready_i ? S_FETCH : S_MEMWR;
      S_REXEC:  w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_IEXEC:  w_next = S_IWB;
      S_IWB:    w_next = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  ctrl_out_decode u_decode (
    .i_state     (r_state),
    .i_op        (w_op),
    .i_mem_ready (mem_ready_i),
    .o_ctrl      (w_ctrl)
  );

  // Everything is held low while reset is asserted, including FETCH's read
  assign w_ctrl_out = rst_i ? '0 : w_ctrl;

  assign pc_write_o      = w_ctrl_out.pc_write;
  assign pc_write_cond_o = w_ctrl_out.pc_write_cond;
  assign pc_src_o        = w_ctrl_out.pc_src;
  assign i_or_d_o        = w_ctrl_out.i_or_d;
  assign mem_read_o      = w_ctrl_out.mem_read;
  assign mem_write_o     = w_ctrl_out.mem_write;
  assign ir_write_o      = w_ctrl_out.ir_write;
  assign reg_write_o     = w_ctrl_out.reg_write;
  assign reg_dst_o       = w_ctrl_out.reg_dst;
  assign mem_to_reg_o    = w_ctrl_out.mem_to_reg;
  assign alu_src_a_o     = w_ctrl_out.alu_src_a;
  assign alu_src_b_o     = w_ctrl_out.alu_src_b;
  assign alu_op_o        = w_ctrl_out.alu_op;
  assign illegal_o       = w_ctrl_out.illegal;
  assign state_o         = rst_i ? '0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed per-cycle vectors pushed into an
// expected queue by the driver, compared by a negedge monitor.
// Vector layout (22 bits):
// {state[3:0], illegal, pc_write, pc_write_cond, pc_src[1:0], i_or_d,
//  mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
//  alu_src_a, alu_src_b[1:0], alu_op[2:0]}
module tb_multicycle_ctrl;

  localparam int W = 22;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic       illegal_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .instr_op_i      (instr_op_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .pc_src_o        (pc_src_o),
    .i_or_d_o        (i_or_d_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .reg_write_o     (reg_write_o),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .illegal_o       (illegal_o),
    .state_o         (state_o)
  );

  // Hand-written expected vector builder (fields in layout order)
  function automatic logic [W-1:0] mk(
    input logic [3:0] st, input logic ill, input logic pcw, input logic pcwc,
    input logic [1:0] pcs, input logic iord, input logic mr, input logic mw,
    input logic irw, input logic rw, input logic rdst, input logic m2r,
    input logic asa, input logic [1:0] asb, input logic [2:0] aop);
    return {st, ill, pcw, pcwc, pcs, iord, mr, mw, irw, rw, rdst, m2r,
            asa, asb, aop};
  endfunction

  logic [W-1:0] V_ZERO, V_FW, V_FR, V_DEC, V_DEC_ILL, V_MADR, V_MRD, V_MWB;
  logic [W-1:0] V_MWR, V_REX, V_RWB, V_BR, V_JMP, V_IADDI, V_ISLTI, V_IWB, V_TRAP;

  // ---------------- driver ----------------
  // Apply inputs for one cycle (just after a rising edge) and queue the
  // outputs expected during that cycle.
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input logic [W-1:0] exp_v);
    instr_op_i  = op;
    mem_ready_i = rdy;
    rst_i       = rst;
    exp_q.push_back(exp_v);
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] act_v;
  assign act_v = {state_o, illegal_o, pc_write_o, pc_write_cond_o, pc_src_o,
                  i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o,
                  reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o};

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (act_v !== e) begin
          n_miss++;
          $display("FAIL vec%0d ctrl got %h expected %h (t=%0t)", n_vec, act_v, e, $time);
        end else if ((mem_read_o && mem_write_o) || (reg_write_o && mem_write_o)) begin
          n_miss++;
          $display("FAIL vec%0d exclusive_strobes got rd=%b wr=%b rw=%b expected no overlap",
                   n_vec, mem_read_o, mem_write_o, reg_write_o);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    V_ZERO    = '0;
    V_FW      = mk(4'd0, 0,0,0,2'd0, 0,1,0,0, 0,0,0, 0,2'd1,3'b000);
    V_FR      = mk(4'd0, 0,1,0,2'd0, 0,1,0,1, 0,0,0, 0,2'd1,3'b000);
    V_DEC     = mk(4'd1, 0,0,0,2'd0, 0,0,0,0, 0,0,0, 0,2'd3,3'b000);
    V_DEC_ILL = mk(4'd1, 1,0,0,2'd0, 0,0,0,0, 0,0,0, 0,2'd3,3'b000);
    V_MADR    = mk(4'd2, 0,0,0,2'd0, 0,0,0,0, 0,0,0, 1,2'd2,3'b000);
    V_MRD     = mk(4'd3, 0,0,0,2'd0, 1,1,0,0, 0,0,0, 0,2'd0,3'b000);
    V_MWB     = mk(4'd4, 0,0,0,2'd0, 0,0,0,0, 1,0,1, 0,2'd0,3'b000);
    V_MWR     = mk(4'd5, 0,0,0,2'd0, 1,0,1,0, 0,0,0, 0,2'd0,3'b000);
    V_REX     = mk(4'd6, 0,0,0,2'd0, 0,0,0,0, 0,0,0, 1,2'd0,3'b010);
    V_RWB     = mk(4'd7, 0,0,0,2'd0, 0,0,0,0, 1,1,0, 0,2'd0,3'b000);
    V_BR      = mk(4'd8, 0,0,1,2'd1, 0,0,0,0, 0,0,0, 1,2'd0,3'b001);
    V_JMP     = mk(4'd9, 0,1,0,2'd2, 0,0,0,0, 0,0,0, 0,2'd0,3'b000);
    V_IADDI   = mk(4'd10,0,0,0,2'd0, 0,0,0,0, 0,0,0, 1,2'd2,3'b100);
    V_ISLTI   = mk(4'd10,0,0,0,2'd0, 0,0,0,0, 0,0,0, 1,2'd2,3'b111);
    V_IWB     = mk(4'd11,0,0,0,2'd0, 0,0,0,0, 1,0,0, 0,2'd0,3'b000);
    V_TRAP    = mk(4'd12,1,0,0,2'd0, 0,0,0,0, 0,0,0, 0,2'd0,3'b000);

    rst_i = 1'b1; instr_op_i = '0; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    step(6'h00, 1'b1, 1'b1, V_ZERO);   // outputs held low in reset even if ready

    // R-type; junk opcode outside DECODE must be ignored
    step(6'h3f, 1'b1, 1'b0, V_FR);
    step(6'b000000, 1'b1, 1'b0, V_DEC);
    step(6'h3f, 1'b1, 1'b0, V_REX);
    step(6'h3f, 1'b1, 1'b0, V_RWB);

    // LW with 3 fetch wait cycles and 2 MEMRD wait cycles
    step(6'h3f, 1'b0, 1'b0, V_FW);
    step(6'h3f, 1'b0, 1'b0, V_FW);
    step(6'h3f, 1'b0, 1'b0, V_FW);
    step(6'h3f, 1'b1, 1'b0, V_FR);
    step(6'b100011, 1'b0, 1'b0, V_DEC);
    step(6'b101011, 1'b1, 1'b0, V_MADR); // SW on the bus, latched LW wins
    step(6'h00, 1'b0, 1'b0, V_MRD);
    step(6'h00, 1'b0, 1'b0, V_MRD);
    step(6'h00, 1'b1, 1'b0, V_MRD);
    step(6'h00, 1'b1, 1'b0, V_MWB);

    // SLTI, ADDI, BEQ, J
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b001010, 1'b1, 1'b0, V_DEC);
    step(6'b001000, 1'b1, 1'b0, V_ISLTI); // latched op decides the class
    step(6'h00, 1'b1, 1'b0, V_IWB);
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b001000, 1'b1, 1'b0, V_DEC);
    step(6'b001010, 1'b1, 1'b0, V_IADDI);
    step(6'h00, 1'b1, 1'b0, V_IWB);
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b000100, 1'b1, 1'b0, V_DEC);
    step(6'h00, 1'b1, 1'b0, V_BR);
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b000010, 1'b1, 1'b0, V_DEC);
    step(6'h00, 1'b1, 1'b0, V_JMP);

    // SW with 4 wait cycles in MEMWR -> mem_write held 5 cycles
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b101011, 1'b1, 1'b0, V_DEC);
    step(6'h00, 1'b1, 1'b0, V_MADR);
    for (int i = 0; i < 4; i++) step(6'h00, 1'b0, 1'b0, V_MWR);
    step(6'h00, 1'b1, 1'b0, V_MWR);

    // Reset in the middle of a stalled MEMRD
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b100011, 1'b1, 1'b0, V_DEC);
    step(6'h00, 1'b0, 1'b0, V_MADR);
    step(6'h00, 1'b0, 1'b0, V_MRD);
    step(6'h00, 1'b0, 1'b1, V_ZERO);
    step(6'h00, 1'b0, 1'b0, V_FW);        // back in FETCH, read re-issued

    // Unsupported opcode
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b111111, 1'b1, 1'b0, V_DEC_ILL);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) step(6'h00, 1'b1, 1'b0, V_TRAP);
    step(6'h00, 1'b1, 1'b1, V_ZERO);
    step(6'h00, 1'b1, 1'b0, V_FR);
`else
    step(6'h00, 1'b1, 1'b0, V_FR);
    step(6'b000000, 1'b1, 1'b0, V_DEC);   // core keeps running normally
    step(6'h00, 1'b1, 1'b0, V_REX);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS-subset CPU. It sequences a shared-memory datapath through fetch, decode, execute, memory and write-back steps.
- Decodes the 6-bit opcode into per-state control strobes for PC, IR, register file, ALU and memory.
- Stalls on a memory ready handshake.
- Replaces the single-cycle combinational decoder at the top level. The existing ALU_Ctrl still consumes alu_op_o.

Parameters:
- OP_W, 6, opcode width.
- ST_W, 4, state register width.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset: one clock; reset is asynchronous and active-high.
- instr_op_i  in  6  opcode field; only sampled in DECODE.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load if ALU zero (beq).
- pc_src_o  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  instruction register load.
- reg_write_o  out  1  register file write.
- reg_dst_o  out  1  1=rd, 0=rt.
- mem_to_reg_o  out  1  1=MDR, 0=ALUOut.
- alu_src_a_o  out  1  0=PC, 1=rs.
- alu_src_b_o  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op_o  out  3  ALU_Ctrl operation class.
- illegal_o  out  1  unsupported opcode seen.
- state_o  out  4  current state (debug).

Behaviour:
- Opcodes (package): R=000000, J=000010, BEQ=000100, ADDI=001000, SLTI=001010, LW=100011, SW=101011.
- alu_op_o classes: ADD=000, SUB=001, RTYPE=010, ADDI=100, SLTI=111.
- States:
  - FETCH=0: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. ir_write and pc_write are asserted only in the cycle mem_ready_i=1 (Mealy qualification). Stay while mem_ready_i=0; go to DECODE when it is 1.
  - DECODE=1: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Transitions: LW/SW->MEMADR, R->REXEC, BEQ->BRANCH, J->JUMP, ADDI/SLTI->IEXEC, other->ILLEGAL handling.
  - MEMADR=2: alu_src_a=1, alu_src_b=2, alu_op=ADD. LW->MEMRD, SW->MEMWR. The opcode is latched in DECODE; instr_op_i is not re-sampled.
  - MEMRD=3: mem_read=1, i_or_d=1. Hold until mem_ready_i, then go to MEMWB.
  - MEMWB=4: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEMWR=5: mem_write=1, i_or_d=1. Hold until mem_ready_i, then go to FETCH.
  - REXEC=6: alu_src_a=1, alu_src_b=0, alu_op=RTYPE. Go to RWB.
  - RWB=7: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_src=1. Go to FETCH.
  - JUMP=9: pc_write=1, pc_src=2. Go to FETCH.
  - IEXEC=10: alu_src_a=1, alu_src_b=2, alu_op=ADDI or SLTI from the latched opcode. Go to IWB.
  - IWB=11: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
  - TRAP=12: only with the optional feature.
- Outputs not listed for a state are 0.
- Reset: state=FETCH and the latched opcode=0 asynchronously. While rst_i=1, all outputs are forced to 0 (including FETCH mem_read). FETCH outputs appear the first cycle after release.
- Reset mid-transaction: the state returns to FETCH immediately and any pending memory request is dropped. No write strobe is asserted while rst_i=1.
- Latency in cycles with mem_ready_i tied high: R=4, ADDI/SLTI=4, LW=5, SW=4, BEQ=3, J=3.
- mem_ready_i is ignored outside FETCH/MEMRD/MEMWR.
- Unused state encodings 13-15 go to FETCH on the next edge and assert illegal_o for that cycle.
- At most one of mem_read_o/mem_write_o is high in any cycle. reg_write_o and mem_write_o are never both high.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE goes to TRAP. TRAP holds all strobes at 0 and illegal_o=1 until rst_i; the core halts.
- Undefined: an unsupported opcode is a NOP. DECODE goes to FETCH and illegal_o pulses high for exactly the DECODE cycle. The PC has already advanced by 4.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - state enum (4-bit, values above);
  - alu_op class constants;
  - alu_src_b and pc_src select constants.
- Sub-module ctrl_out_decode: purely combinational state(+latched op, mem_ready) -> strobe vector. The top keeps the state register, opcode latch and next-state logic.

Test Plan:
- rst_i pulsed mid-MEMRD with mem_ready_i=0 -> all outputs 0 during reset; state_o=0 next cycle; no mem_write_o ever asserted.
- R-type (op 000000), mem_ready_i=1 -> states 0,1,6,7,0. reg_write_o=1 and reg_dst_o=1 only in cycle 4; alu_op_o=010 in cycle 3.
- LW (100011), FETCH ready after 3 wait cycles and MEMRD after 2 -> ir_write_o single pulse in the ready cycle. Sequence 0,0,0,0,1,2,3,3,3,4,0. mem_to_reg_o=1 in state 4.
- SLTI (001010) then BEQ (000100) -> alu_op_o=111 in IEXEC. BEQ state 8 has pc_write_cond_o=1, alu_op_o=001, pc_src_o=1.
- Opcode 111111 -> without macro: illegal_o one-cycle pulse, back to FETCH. With macro: state_o=12, illegal_o stays 1 for 20 cycles, until reset.
- SW (101011) with mem_ready_i=0 for 4 cycles in MEMWR -> mem_write_o held 5 cycles, i_or_d_o=1, reg_write_o never 1.
